warp_arbiter: RTL and testbench
===============================

Name: warp_arbiter

Overview:
- Shares one compute core's fetch/decode/execute pipeline between NUM_WARPS warp contexts of a block.
- Decides which warp owns the pipeline each cycle. Switches away from a warp at safe points when it stalls on fetch/LSU, finishes (RET), or exhausts its time quantum.
- Drives the warp_select mux that picks per-warp core_state/current_pc/LSU banks.
- Sits between the dispatcher (start/done) and the per-warp scheduler contexts.

Parameters:
- NUM_WARPS, 2, number of warp contexts sharing the core (2..8).
- QUANTUM, 16, maximum consecutive RUN cycles for one warp before preemption is considered (>=2).
- WID_BITS, $clog2(NUM_WARPS) (min 1), width of the warp index (localparam, not overridable).

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  block launched by dispatcher; held high until all_done is seen.
- warp_stalled  in  NUM_WARPS  per-warp: context is in FETCH awaiting fetcher, or WAIT with an LSU REQUESTING/WAITING.
- warp_done  in  NUM_WARPS  per-warp: context reached CORE_DONE (RET executed).
- switch_safe  in  1  active warp's core_state is FETCH, WAIT or DONE (no in-flight decode/execute/update).
- warp_select  out  WID_BITS  index of the warp owning the pipeline.
- warp_valid  out  1  pipeline may advance the selected warp this cycle.
- switch_pulse  out  1  one-cycle pulse in the bubble cycle after warp_select changes.
- all_done  out  1  every warp has reported done.

Behaviour:
- Reset (async, immediate):
  - state=ARB_IDLE; warp_select=0, warp_valid=0, switch_pulse=0, all_done=0.
  - done_mask=0, quantum counter=0.
  - Reset mid-RUN or mid-SWITCH abandons the block with no further switch_pulse.
- done_mask[i] is set on any cycle with warp_done[i]=1 in RUN or SWITCH. It is cleared only on the DONE->IDLE transition or reset.
- Eligibility sets:
  - ready = ~done_mask & ~warp_done & ~warp_stalled.
  - live = ~done_mask & ~warp_done.
- Round-robin pick: the first index after warp_select (wrapping modulo NUM_WARPS, current warp searched last) set in ready. If ready has no other index, use live instead. The rr_picker sub-module computes this.
- ARB_IDLE:
  - warp_valid=0.
  - On start=1: go to RUN next cycle with warp_select=0, counter=0, warp_valid=1. No switch_pulse on initial entry.
- ARB_RUN:
  - warp_valid=1; counter increments and saturates at QUANTUM.
  - Switch triggers, evaluated only when switch_safe=1:
    - (a) the active warp is in live' complement, i.e. it is done.
    - (b) warp_stalled[active]=1 and another ready warp exists.
    - (c) `WARP_QUANTUM_EN is defined, counter>=QUANTUM, and another ready warp exists.
  - Priority is (a) > (b) > (c).
  - On a trigger: warp_select<=pick, warp_valid<=0, state->SWITCH.
  - If (a) holds and live is empty: state->DONE.
  - If all other warps are stalled on (b): stay on the current warp with no switch.
  - If a trigger holds while switch_safe=0: hold and re-evaluate every cycle.
- ARB_SWITCH:
  - Exactly one bubble cycle: warp_valid=0, switch_pulse=1, counter<=0, state->RUN.
  - Switch latency from trigger to the new warp valid is 2 cycles.
- ARB_DONE:
  - all_done=1, warp_valid=0, warp_select holds.
  - On start=0: go to IDLE, all_done<=0, done_mask<=0, warp_select<=0.
- Simultaneous done of the active warp and the last other warp: DONE, no SWITCH.
- start dropping in RUN or SWITCH is ignored; only reset aborts.
- NUM_WARPS=1: warp_select stays 0. Only trigger (a) ever fires, and it goes straight to DONE.

Optional Feature:
- Macro: WARP_QUANTUM_EN.
- Defined: the quantum counter and trigger (c) are built, giving time-sliced fairness among non-stalled warps.
- Undefined: the counter is removed. Switches occur only on stall or done, and QUANTUM is unused.

Decomposition:
- enums.svh package additions:
  - arb_state_t: ARB_IDLE, ARB_RUN, ARB_SWITCH, ARB_DONE (2-bit).
  - The switch_safe derivation helper constant set (CORE_FETCH, CORE_WAIT, CORE_DONE).
- Sub-module rr_picker, purely combinational: inputs request mask and current index; outputs next index and found flag. It is instantiated twice, once for ready and once for live.

Test Plan:
- NUM_WARPS=2, start=1, no stalls, warp 0 warp_done at cycle 10 with switch_safe=1 -> switch_pulse at 11, warp_select=1 and warp_valid=1 at 12; warp 1 done -> all_done=1, then start=0 -> IDLE, done_mask=0.
- Warp 0 warp_stalled=1, switch_safe=1, warp 1 ready -> warp_select 0->1 with a 1-cycle bubble. Same case with warp 1 also stalled -> no switch, warp_select stays 0.
- WARP_QUANTUM_EN, QUANTUM=4, both ready, switch_safe=1 -> warp_select toggles every 5 cycles (4 RUN + 1 SWITCH). Without the macro -> warp_select stays 0 indefinitely.
- Trigger held with switch_safe=0 for 3 cycles -> no switch; switch_pulse one cycle after switch_safe rises.
- NUM_WARPS=4, warps 1 and 2 done, warp 0 stalls -> pick is 3 (skips done warps, wraps correctly).
- Assert reset mid-SWITCH -> outputs are 0 immediately, without waiting for a clk edge; after release, start restarts at warp 0.

Source files
------------

// File: rtl/warp_arbiter_pkg.sv
// Shared constants for the warp arbiter: arbiter FSM encoding, core-state codes, width helper.
package warp_arbiter_pkg;

   typedef logic [1:0] arb_state_t;

   localparam arb_state_t ARB_IDLE   = 2'd0;
   localparam arb_state_t ARB_RUN    = 2'd1;
   localparam arb_state_t ARB_SWITCH = 2'd2;
   localparam arb_state_t ARB_DONE   = 2'd3;

   // Per-warp core_state codes; a warp may be swapped out only in FETCH, WAIT or DONE.
   localparam logic [2:0] CORE_IDLE    = 3'd0;
   localparam logic [2:0] CORE_FETCH   = 3'd1;
   localparam logic [2:0] CORE_DECODE  = 3'd2;
   localparam logic [2:0] CORE_REQUEST = 3'd3;
   localparam logic [2:0] CORE_WAIT    = 3'd4;
   localparam logic [2:0] CORE_EXECUTE = 3'd5;
   localparam logic [2:0] CORE_UPDATE  = 3'd6;
   localparam logic [2:0] CORE_DONE    = 3'd7;

   function automatic logic core_switch_safe(input logic [2:0] core_state);
      return (core_state == CORE_FETCH) || (core_state == CORE_WAIT) ||
             (core_state == CORE_DONE);
   endfunction

   function automatic int wid_bits(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/warp_arbiter_rr_picker.sv
// Combinational round-robin search: first requester after cur_i, wrapping, cur_i itself checked last.
module warp_arbiter_rr_picker
   import warp_arbiter_pkg::*;
#(
   parameter int N = 2,
   parameter int W = wid_bits(N)
) (
   input  logic [N-1:0] req_i,
   input  logic [W-1:0] cur_i,
   output logic [W-1:0] next_o,
   output logic         found_o
);

   always_comb begin
      int idx;
      idx     = 0;
      next_o  = cur_i;
      found_o = 1'b0;
      for (int k = 1; k <= N; k++) begin
         idx = (int'(cur_i) + k) % N;
         if (!found_o && req_i[idx]) begin
            found_o = 1'b1;
            next_o  = W'(idx);
         end
      end
   end

endmodule

// File: rtl/warp_arbiter.sv
// Time-multiplexes one core pipeline between NUM_WARPS warp contexts.
// Optional time-slice preemption is built when WARP_QUANTUM_EN is defined.
module warp_arbiter
   import warp_arbiter_pkg::*;
#(
   parameter  int NUM_WARPS = 2,
   parameter  int QUANTUM   = 16,
   localparam int WID_BITS  = wid_bits(NUM_WARPS),
   localparam int CNT_W     = $clog2(QUANTUM + 1)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [NUM_WARPS-1:0] warp_stalled,
   input  logic [NUM_WARPS-1:0] warp_done,
   input  logic                 switch_safe,
   output logic [WID_BITS-1:0]  warp_select,
   output logic                 warp_valid,
   output logic                 switch_pulse,
   output logic                 all_done,
   output logic [1:0]           dbg_state_o,
   output logic [CNT_W-1:0]     dbg_count_o
);

   // valid/ready: the pipeline advances warp_select only in cycles where warp_valid=1;
   // the arbiter never waits on the pipeline, it only observes switch_safe.

   arb_state_t           state_q, state_d;
   logic [WID_BITS-1:0]  sel_q, sel_d;
   logic [NUM_WARPS-1:0] mask_q, mask_d;

   logic [NUM_WARPS-1:0] live, ready, sel_oh;
   logic [WID_BITS-1:0]  ready_next, live_next, pick;
   logic                 ready_found, live_found, others_ready, act_done, quantum_hit;

   assign live  = ~mask_q & ~warp_done;
   assign ready = live & ~warp_stalled;

   always_comb begin
      sel_oh        = '0;
      sel_oh[sel_q] = 1'b1;
   end

   assign others_ready = |(ready & ~sel_oh);
   assign act_done     = ~live[sel_q];

   warp_arbiter_rr_picker #(.N(NUM_WARPS), .W(WID_BITS)) u_pick_ready (
      .req_i   (ready),
      .cur_i   (sel_q),
      .next_o  (ready_next),
      .found_o (ready_found)
   );

   warp_arbiter_rr_picker #(.N(NUM_WARPS), .W(WID_BITS)) u_pick_live (
      .req_i   (live),
      .cur_i   (sel_q),
      .next_o  (live_next),
      .found_o (live_found)
   );

   // The ready search reaches the current warp last, so it only wins when nothing else is ready.
   assign pick = (ready_found && others_ready) ? ready_next : live_next;

`ifdef WARP_QUANTUM_EN
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = '0;
      if (state_q == ARB_RUN) begin
         cnt_d = (cnt_q == CNT_W'(QUANTUM)) ? cnt_q : cnt_q + CNT_W'(1);
      end
   end

   // cnt_q counts earlier RUN cycles, so the QUANTUM-th consecutive RUN cycle is the last one.
   assign quantum_hit = (cnt_q >= CNT_W'(QUANTUM - 1));
   assign dbg_count_o = cnt_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end
`else
   assign quantum_hit = 1'b0;
   assign dbg_count_o = '0;
`endif

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      mask_d  = mask_q;
      case (state_q)
         ARB_IDLE: begin
            if (start) begin
               state_d = ARB_RUN;
               sel_d   = '0;
            end
         end
         ARB_RUN: begin
            mask_d = mask_q | warp_done;
            if (switch_safe) begin
               if (act_done) begin
                  if (!live_found) begin
                     state_d = ARB_DONE;
                  end else begin
                     state_d = ARB_SWITCH;
                     sel_d   = pick;
                  end
               end else if ((warp_stalled[sel_q] || quantum_hit) && others_ready) begin
                  state_d = ARB_SWITCH;
                  sel_d   = pick;
               end
            end
         end
         ARB_SWITCH: begin
            mask_d  = mask_q | warp_done;
            state_d = ARB_RUN;
         end
         ARB_DONE: begin
            if (!start) begin
               state_d = ARB_IDLE;
               mask_d  = '0;
               sel_d   = '0;
            end
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ARB_IDLE;
         sel_q   <= '0;
         mask_q  <= '0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         mask_q  <= mask_d;
      end
   end

   // Outputs decode straight from registered state, so reset clears them without a clock edge.
   assign warp_select  = sel_q;
   assign warp_valid   = (state_q == ARB_RUN);
   assign switch_pulse = (state_q == ARB_SWITCH);
   assign all_done     = (state_q == ARB_DONE);
   assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_warp_arbiter.sv
// Randomized scoreboard bench for warp_arbiter with four warps and a behavioural reference model.
module tb_warp_arbiter;

   localparam int NW = 4;
   localparam int Q  = 4;
   localparam int WB = 2;
   localparam int PH_IDLE = 0, PH_RUN = 1, PH_BUBBLE = 2, PH_DONE = 3;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [NW-1:0] warp_stalled;
   logic [NW-1:0] warp_done;
   logic          switch_safe;
   logic [WB-1:0] warp_select;
   logic          warp_valid;
   logic          switch_pulse;
   logic          all_done;
   logic [1:0]    dbg_state;
   logic [2:0]    dbg_count;

   int checks   = 0;
   int failures = 0;

   logic [4:0]    exp_q[$];
   logic [WB-1:0] sw_q[$];

   int            m_ph;
   int            m_sel;
   bit [NW-1:0]   m_done;
   int            m_runs;

   warp_arbiter #(.NUM_WARPS(NW), .QUANTUM(Q)) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .warp_stalled (warp_stalled),
      .warp_done    (warp_done),
      .switch_safe  (switch_safe),
      .warp_select  (warp_select),
      .warp_valid   (warp_valid),
      .switch_pulse (switch_pulse),
      .all_done     (all_done),
      .dbg_state_o  (dbg_state),
      .dbg_count_o  (dbg_count)
   );

   always #5 clk = ~clk;

   // First set member after cur going upward with wrap, cur itself last; -1 if the set is empty.
   function automatic int rr_first(input bit [NW-1:0] m, input int cur);
      for (int d = 1; d <= NW; d++) begin
         if (m[(cur + d) % NW]) return (cur + d) % NW;
      end
      return -1;
   endfunction

   task automatic model_step(input bit rst, input bit st, input bit ss,
                             input bit [NW-1:0] ws, input bit [NW-1:0] wd);
      bit [NW-1:0] live, ready, me;
      int          other, next_sel;
      bit          slice_up;
      if (rst) begin
         m_ph = PH_IDLE; m_sel = 0; m_done = '0; m_runs = 0;
      end else begin
         case (m_ph)
            PH_IDLE: if (st) begin m_ph = PH_RUN; m_sel = 0; m_runs = 0; end
            PH_RUN: begin
               live      = ~m_done & ~wd;
               ready     = live & ~ws;
               me        = '0;
               me[m_sel] = 1'b1;
               other     = rr_first(ready & ~me, m_sel);
`ifdef WARP_QUANTUM_EN
               slice_up  = (m_runs + 1 >= Q);
`else
               slice_up  = 1'b0;
`endif
               m_done    = m_done | wd;
               next_sel  = -1;
               if (ss) begin
                  if (!live[m_sel]) begin
                     if (live == '0) m_ph = PH_DONE;
                     else next_sel = (other >= 0) ? other : rr_first(live, m_sel);
                  end else if (other >= 0 && (ws[m_sel] || slice_up)) begin
                     next_sel = other;
                  end
               end
               if (next_sel >= 0) begin
                  m_ph  = PH_BUBBLE;
                  m_sel = next_sel;
                  sw_q.push_back(WB'(m_sel));
               end
               m_runs = (m_ph == PH_RUN) ? m_runs + 1 : 0;
            end
            PH_BUBBLE: begin m_done = m_done | wd; m_ph = PH_RUN; m_runs = 0; end
            default: if (!st) begin m_ph = PH_IDLE; m_done = '0; m_sel = 0; end
         endcase
      end
      exp_q.push_back({WB'(m_sel), m_ph == PH_RUN, m_ph == PH_BUBBLE, m_ph == PH_DONE});
   endtask

   task automatic check_reset_outputs(input string tag);
      checks++;
      if ({warp_select, warp_valid, switch_pulse, all_done} !== 5'b0) begin
         failures++;
         $display("FAIL %s: sel=%0d valid=%0b pulse=%0b all_done=%0b, required all zero",
                  tag, warp_select, warp_valid, switch_pulse, all_done);
      end
   endtask

   task automatic drive(input bit rst, input bit st, input bit ss,
                        input bit [NW-1:0] ws, input bit [NW-1:0] wd, input bit chk);
      @(negedge clk);
      reset = rst; start = st; switch_safe = ss; warp_stalled = ws; warp_done = wd;
      if (chk) begin
         #1;
         check_reset_outputs("async_reset");
      end
      model_step(rst, st, ss, ws, wd);
   endtask

   initial begin : monitor
      logic [4:0]    exp_v, act_v;
      logic [WB-1:0] exp_s;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            act_v = {warp_select, warp_valid, switch_pulse, all_done};
            checks++;
            if (act_v !== exp_v) begin
               failures++;
               $display("FAIL outputs @%0t: {sel,valid,pulse,done} got %b, required %b",
                        $time, act_v, exp_v);
            end
         end
         if (switch_pulse === 1'b1) begin
            checks++;
            if (sw_q.size() == 0) begin
               failures++;
               $display("FAIL switch_unexpected @%0t: pulse with sel=%0d, no switch required",
                        $time, warp_select);
            end else begin
               exp_s = sw_q.pop_front();
               if (warp_select !== exp_s) begin
                  failures++;
                  $display("FAIL switch_target @%0t: sel=%0d, required %0d",
                           $time, warp_select, exp_s);
               end
            end
         end
      end
   end

   initial begin : stimulus
      bit          r, s, ss;
      bit [NW-1:0] ws, wd;
      bit          chk;
      reset = 1'b1; start = 1'b0; switch_safe = 1'b0;
      warp_stalled = '0; warp_done = '0;
      m_ph = PH_IDLE; m_sel = 0; m_done = '0; m_runs = 0;
      #1;
      check_reset_outputs("reset_state");
      drive(1, 0, 0, 4'b0000, 4'b0000, 0);
      drive(1, 0, 0, 4'b0000, 4'b0000, 0);
      // Directed opening: long run with nothing stalled, then done and stall driven switches.
      for (int i = 0; i < 12; i++) drive(0, 1, 1, 4'b0000, 4'b0000, 0);
      drive(0, 1, 1, 4'b0000, 4'b0001, 0);
      for (int i = 0; i < 4; i++) drive(0, 1, 1, 4'b0000, 4'b0000, 0);
      for (int i = 0; i < 3; i++) drive(0, 1, 0, 4'b0010, 4'b0000, 0);
      drive(0, 1, 1, 4'b0010, 4'b0000, 0);
      for (int i = 0; i < 3; i++) drive(0, 1, 1, 4'b0000, 4'b0000, 0);
      drive(0, 1, 1, 4'b0000, 4'b0110, 0);
      for (int i = 0; i < 3; i++) drive(0, 1, 1, 4'b1000, 4'b0000, 0);
      drive(0, 1, 1, 4'b0000, 4'b1000, 0);
      for (int i = 0; i < 3; i++) drive(0, 0, 1, 4'b0000, 4'b0000, 0);

      for (int i = 0; i < 3000; i++) begin
         r   = 1'b0;
         chk = 1'b0;
         if (m_ph == PH_BUBBLE && $urandom_range(0, 3) == 0) begin
            r = 1'b1; chk = 1'b1;
         end else if ($urandom_range(0, 499) == 0) begin
            r = 1'b1;
         end
         case (m_ph)
            PH_DONE:  s = ($urandom_range(0, 2) == 0);
            PH_IDLE:  s = ($urandom_range(0, 1) == 0);
            default:  s = ($urandom_range(0, 49) != 0);
         endcase
         ss = ($urandom_range(0, 9) < 7);
         for (int b = 0; b < NW; b++) begin
            ws[b] = ($urandom_range(0, 9) < 3);
            wd[b] = ($urandom_range(0, 29) == 0);
         end
         drive(r, s, ss, ws, wd, chk);
      end

      @(posedge clk);
      #3;
      checks++;
      if (exp_q.size() != 0 || sw_q.size() != 0) begin
         failures++;
         $display("FAIL drain: %0d output and %0d switch expectations left, required 0",
                  exp_q.size(), sw_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
